ccff_multichain_loader: RTL
===========================

Name: ccff_multichain_loader

Overview:
- Parametrised configuration-chain programmer that drives NUM_CHAINS parallel ccff chains across a column of CLB tiles.
- Each chain is built from grid_clb ccff_head→ccff_tail links.
- Takes a bitstream beat stream over a valid/ready handshake and shifts one bit per chain per beat.
- Optional second pass re-shifts the same stream, compares each chain's ccff_tail against it, and flags per-chain mismatches; the chain contents are left intact.

Parameters:
- NUM_CHAINS, 4, number of independent config chains driven in parallel.
- CHAIN_LEN, 1024, config bits per chain (all chains equal length).
- CNT_W, $clog2(CHAIN_LEN+1), beat-counter width (derived, not overridden).
- ERR_W, 16, width of the saturating mismatch counter.

Ports:
- prog_clk  in  1  programming clock; all state updates on its rising edge.
- pReset  in  1  synchronous, active-high reset.
- Test_en  in  1  scan/test mode; freezes all shifting while high.
- start  in  1  one-cycle pulse; begins a program operation when idle.
- verify_en  in  1  sampled with start; 1 = load pass followed by verify pass.
- abort  in  1  one-cycle pulse; terminates any operation.
- cfg_valid  in  1  beat valid.
- cfg_data  in  NUM_CHAINS  one bit per chain for this beat.
- cfg_ready  out  1  beat accepted when cfg_valid & cfg_ready.
- ccff_head  out  NUM_CHAINS  registered serial data to each chain head.
- ccff_shift_en  out  1  chain shift enable; drives the external prog_clk gate.
- ccff_tail  in  NUM_CHAINS  chain tail bits.
- busy  out  1  high in LOAD or VERIFY.
- verify_phase  out  1  high in VERIFY.
- done  out  1  one-cycle pulse on normal completion.
- err_chain  out  NUM_CHAINS  sticky per-chain mismatch flags.
- err_count  out  ERR_W  total mismatched bits, saturating at all-ones.

Behaviour:
- Reset (pReset=1): state IDLE, beat_cnt=0, head_q=0, en_q=0.
- Reset values of outputs: cfg_ready=0, ccff_head=0, ccff_shift_en=0, busy=0, verify_phase=0, done=0, err_chain=0, err_count=0.
- Reset has priority over abort, which has priority over start.
- FSM states: IDLE, LOAD, VERIFY.
- IDLE→LOAD on start. On that transition: clear err_chain, err_count and beat_cnt; latch verify_en into mode_q.
- start while busy is ignored.
- cfg_ready = (state is LOAD or VERIFY) & (beat_cnt < CHAIN_LEN) & ~Test_en.
- On accept:
  - head_q <= cfg_data.
  - en_q <= 1.
  - beat_cnt increments.
- Cycles with no accept and Test_en=0: en_q <= 0, head_q holds.
- While Test_en=1: en_q and head_q hold; a pending shift stays pending.
- ccff_shift_en = en_q & ~Test_en. ccff_head = head_q.
- Latency: a beat accepted in cycle t is shifted into the chains at the end of cycle t+1. Back-to-back beats sustain 1 beat/cycle.
- Verify comparison:
  - Active only in verify-pass shift cycles, i.e. ccff_shift_en=1 with the shifted beat belonging to VERIFY.
  - For each chain c with ccff_tail[c] != head_q[c]: set err_chain[c]; err_count += 1 per mismatching chain, saturating.
  - In the shift cycle of verify beat k, the tail holds load beat k.
- Pass end: when the accepted beat makes beat_cnt == CHAIN_LEN, the pass is complete.
  - mode_q=1 and in LOAD: go to VERIFY with beat_cnt=0; cfg_ready may stay high with no bubble.
  - Otherwise: go to IDLE after the final shift cycle.
  - done pulses in the cycle after the final shift, so the last comparison is included.
- abort: next state IDLE, en_q <= 0, no done pulse. err_chain and err_count are retained; chain contents are undefined.
- pReset mid-operation: identical to reset; the pending shift is discarded.
- CHAIN_LEN must be ≥1. NUM_CHAINS must be ≥1.

Decomposition:
- Shared package ccff_loader_pkg holds:
  - the state enum (IDLE/LOAD/VERIFY);
  - the derived-width function for CNT_W.
- Sub-module ccff_tail_checker: per-chain XOR compare, sticky flags, saturating popcount adder into err_count.
- The FSM, counter and head/enable registers stay in the top module.

Test Plan (bench with NUM_CHAINS=2, CHAIN_LEN=8, behavioural shift-register chain model gated by ccff_shift_en):
- Load-only: start, verify_en=0, 8 beats with chain0=0xA5 and chain1=0x3C, sent LSB first → model holds 0xA5/0x3C; done pulses 2 cycles after the last accept; err_count=0.
- Load+verify, same stream sent twice (16 beats, continuous valid) → cfg_ready stays high across the pass boundary; done after the 16th shift; err_chain=00; chain contents still 0xA5/0x3C.
- Verify with chain1 tail forced stuck-at-0 → err_chain=10; err_count=4, the popcount of 0x3C.
- Test_en pulsed high for 3 cycles mid-load, with cfg_valid held → no ccff_shift_en during those cycles; final contents correct; total cycles grow by 3.
- abort after beat 5 → IDLE next cycle; no done; busy=0; a subsequent start completes normally.
- pReset asserted while en_q=1 → ccff_shift_en=0 the next cycle; all outputs take their reset values.

Source files
------------

// File: rtl/ccff_loader_pkg.sv
// Shared types and helpers for the multi-chain ccff configuration loader.
// Holds the loader state encoding and the beat-counter width derivation.
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_VERIFY = 2'd2
  } ccff_state_e;

  // Counter must reach CHAIN_LEN itself, hence len+1 values.
  function automatic int cnt_width(input int len);
    return $clog2(len + 1);
  endfunction

endpackage

// File: rtl/ccff_tail_checker.sv
// Compares each chain tail against the re-shifted head bit during verify shifts.
// Keeps sticky per-chain flags and a saturating count of mismatched bits.
module ccff_tail_checker
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int ERR_W      = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  clr,
  input  logic                  cmp_en,
  input  logic [NUM_CHAINS-1:0] head,
  input  logic [NUM_CHAINS-1:0] tail,
  output logic [NUM_CHAINS-1:0] err_chain,
  output logic [ERR_W-1:0]      err_count
);

  logic [NUM_CHAINS-1:0] miss_s;
  logic [ERR_W:0]        pop_s;
  logic [ERR_W:0]        sum_s;
  logic [ERR_W-1:0]      sat_s;
  logic [NUM_CHAINS-1:0] err_chain_r;
  logic [ERR_W-1:0]      err_count_r;

  // Mismatch vector, its popcount and the saturated running total.
  always_comb begin
    if (cmp_en) begin
      miss_s = head ^ tail;
    end else begin
      miss_s = {NUM_CHAINS{1'b0}};
    end
    pop_s = {(ERR_W+1){1'b0}};
    for (int i = 0; i < NUM_CHAINS; i++) begin
      pop_s = pop_s + {{ERR_W{1'b0}}, miss_s[i]};
    end
    sum_s = {1'b0, err_count_r} + pop_s;
    if (sum_s[ERR_W]) begin
      sat_s = {ERR_W{1'b1}};
    end else begin
      sat_s = sum_s[ERR_W-1:0];
    end
  end

  // Sticky flags and counter; cleared by reset or at the start of an operation.
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      err_chain_r <= {NUM_CHAINS{1'b0}};
      err_count_r <= {ERR_W{1'b0}};
    end else begin
      err_chain_r <= err_chain_r | miss_s;
      err_count_r <= sat_s;
    end
  end

  assign err_chain = err_chain_r;
  assign err_count = err_count_r;

endmodule

// File: rtl/ccff_multichain_loader.sv
// Programs NUM_CHAINS parallel ccff chains from a valid/ready bit stream, one bit
// per chain per beat, with an optional verify pass comparing chain tails.
module ccff_multichain_loader
  import ccff_loader_pkg::*;
#(
  parameter int NUM_CHAINS = 4,
  parameter int CHAIN_LEN  = 1024,
  parameter int ERR_W      = 16
) (
  input  logic                  prog_clk,
  input  logic                  pReset,
  input  logic                  Test_en,
  input  logic                  start,
  input  logic                  verify_en,
  input  logic                  abort,
  input  logic                  cfg_valid,
  input  logic [NUM_CHAINS-1:0] cfg_data,
  output logic                  cfg_ready,
  output logic [NUM_CHAINS-1:0] ccff_head,
  output logic                  ccff_shift_en,
  input  logic [NUM_CHAINS-1:0] ccff_tail,
  output logic                  busy,
  output logic                  verify_phase,
  output logic                  done,
  output logic [NUM_CHAINS-1:0] err_chain,
  output logic [ERR_W-1:0]      err_count
);

  localparam int               CNT_W    = cnt_width(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  ccff_state_e           state_r, next_state_s;
  logic [CNT_W-1:0]      beat_cnt_r;
  logic [NUM_CHAINS-1:0] head_r;
  logic                  en_r;
  logic                  mode_r;
  logic                  verify_r;  // pending shift belongs to the verify pass
  logic                  last_r;    // pending shift is the final one of the operation
  logic                  done_r;

  logic ready_s, accept_s, shift_s, pass_end_s, continue_s, final_shift_s, start_ok_s;

  assign ready_s       = (state_r != ST_IDLE) & (beat_cnt_r < LAST_CNT) & ~Test_en;
  assign accept_s      = cfg_valid & ready_s;
  assign shift_s       = en_r & ~Test_en;
  assign pass_end_s    = accept_s & (beat_cnt_r == LAST_IDX);
  assign continue_s    = pass_end_s & mode_r & (state_r == ST_LOAD);
  assign final_shift_s = shift_s & last_r;
  assign start_ok_s    = (state_r == ST_IDLE) & start & ~abort;

  // Next-state selection; abort overrides everything except reset.
  always_comb begin
    next_state_s = state_r;
    if (abort) begin
      next_state_s = ST_IDLE;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (start) next_state_s = ST_LOAD;
          else       next_state_s = ST_IDLE;
        end
        ST_LOAD: begin
          if (continue_s)         next_state_s = ST_VERIFY;
          else if (final_shift_s) next_state_s = ST_IDLE;
          else                    next_state_s = ST_LOAD;
        end
        ST_VERIFY: begin
          if (final_shift_s) next_state_s = ST_IDLE;
          else               next_state_s = ST_VERIFY;
        end
        default: next_state_s = ST_IDLE;
      endcase
    end
  end

  // State, beat counter and the head/enable pipeline stage.
  always_ff @(posedge prog_clk) begin
    if (pReset) begin
      state_r    <= ST_IDLE;
      beat_cnt_r <= {CNT_W{1'b0}};
      head_r     <= {NUM_CHAINS{1'b0}};
      en_r       <= 1'b0;
      mode_r     <= 1'b0;
      verify_r   <= 1'b0;
      last_r     <= 1'b0;
      done_r     <= 1'b0;
    end else begin
      state_r <= next_state_s;
      done_r  <= final_shift_s & ~abort;
      if (start_ok_s) begin
        beat_cnt_r <= {CNT_W{1'b0}};
        mode_r     <= verify_en;
      end else if (accept_s) begin
        beat_cnt_r <= continue_s ? {CNT_W{1'b0}} : beat_cnt_r + CNT_ONE;
      end
      if (abort) begin
        en_r   <= 1'b0;
        last_r <= 1'b0;
      end else if (accept_s) begin
        head_r   <= cfg_data;
        en_r     <= 1'b1;
        verify_r <= (state_r == ST_VERIFY);
        last_r   <= pass_end_s & ~continue_s;
      end else if (!Test_en) begin
        en_r   <= 1'b0;
        last_r <= 1'b0;
      end
    end
  end

  ccff_tail_checker #(
    .NUM_CHAINS (NUM_CHAINS),
    .ERR_W      (ERR_W)
  ) u_checker (
    .clk       (prog_clk),
    .rst       (pReset),
    .clr       (start_ok_s),
    .cmp_en    (shift_s & verify_r),
    .head      (head_r),
    .tail      (ccff_tail),
    .err_chain (err_chain),
    .err_count (err_count)
  );

  assign cfg_ready     = ready_s;
  assign ccff_head     = head_r;
  assign ccff_shift_en = shift_s;
  assign busy          = (state_r != ST_IDLE);
  assign verify_phase  = (state_r == ST_VERIFY);
  assign done          = done_r;

endmodule
